// File: rtl/otp_mixer.sv
// otp_mixer: one-time-pad mixer. Holds RAM_BLOCKS blocks of 1024 nibbles.
// The SD side reads and writes the blocks through its own port.
// A mix engine XORs one whole block at a time with a 32-bit keystream, one nibble per
// key nibble, and fetches a fresh key word for every 8 nibbles.
// Optional feature macro: OTP_MIXER_COLLISION_EN enables the sticky ocollision flag.
// When the macro is undefined, ocollision is tied low, but the conflicting write is still dropped.
module otp_mixer #(
    parameter int RAM_BLOCKS = 8
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          igen_otp,
    input  logic                          inew_otp,
    output logic                          ootp_ready,
    input  logic [$clog2(RAM_BLOCKS)-1:0] isel_ram,
    input  logic [9:0]                    iaddr,
    input  logic [3:0]                    iwdata,
    input  logic                          iwrite_en,
    output logic [3:0]                    ordata,
    output logic                          okey_init,
    output logic                          okey_req,
    input  logic                          ikey_valid,
    input  logic [31:0]                   ikey,
    output logic                          ocollision
);

    localparam int BLK_W  = $clog2(RAM_BLOCKS);
    localparam int ADDR_W = BLK_W + 10;
    localparam int DEPTH  = RAM_BLOCKS * 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KREQ,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BLK_W-1:0]  r_blk;
    logic [9:0]        r_n;
    logic [31:0]       r_key;
    logic [3:0]        r_mix_rd;
    logic              r_ready;
    logic              r_key_init;
    logic [3:0]        r_rdata;
    logic [3:0]        r_mem [DEPTH];

    logic [ADDR_W-1:0] w_sd_addr;
    logic [ADDR_W-1:0] w_mix_addr;
    logic              w_busy;
    logic              w_sd_drop;
    logic              w_sd_we;
    logic              w_mix_we;
    logic [3:0]        w_key_nib;

    // Block-major linear addressing: each block is 1024 nibbles, so {block, nibble} is the flat index.
    assign w_sd_addr  = {isel_ram, iaddr};
    assign w_mix_addr = {r_blk, r_n};

    // The engine owns the current block while it is mixing.
    // An SD write that hits the block being mixed would race the engine's read-modify-write, so it is discarded.
    assign w_busy    = (r_state == S_KREQ) || (r_state == S_RD) || (r_state == S_WR);
    assign w_sd_drop = iwrite_en && w_busy && (isel_ram == r_blk);
    assign w_sd_we   = iwrite_en && !w_sd_drop;

    // An abort or reset on the same edge as a WR cancels that write.
    // The block is left exactly as mixed so far.
    assign w_mix_we  = (r_state == S_WR) && irst && !inew_otp;
    assign w_key_nib = r_key[{r_n[2:0], 2'b00} +: 4];

    assign okey_req   = (r_state == S_KREQ);
    assign okey_init  = r_key_init;
    assign ootp_ready = r_ready;
    assign ordata     = r_rdata;

    // Storage array, its two write ports, the engine's read port and the key latch (none of this is reset).
    always_ff @(posedge iclk) begin
        if (w_sd_we) begin
            r_mem[w_sd_addr] <= iwdata;
        end
        if (w_mix_we) begin
            r_mem[w_mix_addr] <= r_mix_rd ^ w_key_nib;
        end
        if (r_state == S_RD) begin
            r_mix_rd <= r_mem[w_mix_addr];
        end
        if ((r_state == S_KREQ) && ikey_valid) begin
            r_key <= ikey;
        end
    end

    // SD-side registered read data; it is cleared by reset.
    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_rdata <= 4'h0;
        end else begin
            r_rdata <= r_mem[w_sd_addr];
        end
    end

    // FSM state register.
    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic. inew_otp overrides every state, including a simultaneous igen_otp.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (igen_otp) w_state_nxt = S_KREQ;
            S_KREQ: if (ikey_valid) w_state_nxt = S_RD;
            S_RD:   w_state_nxt = S_WR;
            S_WR: begin
                if (r_n == 10'd1023) begin
                    w_state_nxt = S_DONE;
                end else if (r_n[2:0] == 3'd7) begin
                    w_state_nxt = S_KREQ;
                end else begin
                    w_state_nxt = S_RD;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (inew_otp) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Control registers: block pointer, nibble counter, ready flag and the reseed pulse.
    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_blk      <= '0;
            r_n        <= 10'd0;
            r_ready    <= 1'b0;
            r_key_init <= 1'b0;
        end else begin
            r_key_init <= inew_otp;
            if (inew_otp) begin
                r_blk   <= '0;
                r_n     <= 10'd0;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (igen_otp) begin
                            r_ready <= 1'b0;
                            r_n     <= 10'd0;
                        end
                    end
                    S_WR: begin
                        if (r_n != 10'd1023) begin
                            r_n <= r_n + 10'd1;
                        end
                    end
                    S_DONE: begin
                        r_ready <= 1'b1;
                        if (r_blk == BLK_W'(RAM_BLOCKS - 1)) begin
                            r_blk <= '0;
                        end else begin
                            r_blk <= r_blk + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef OTP_MIXER_COLLISION_EN
    logic r_coll;

    // Sticky record of a dropped SD write. Only reset or a pad restart clears it.
    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_coll <= 1'b0;
        end else if (inew_otp) begin
            r_coll <= 1'b0;
        end else if (w_sd_drop) begin
            r_coll <= 1'b1;
        end
    end

    assign ocollision = r_coll;
`else
    assign ocollision = 1'b0;
`endif

endmodule

// File: tb/tb_otp_mixer.sv
// tb_otp_mixer: directed bench for otp_mixer.
// Read data flows through a scoreboard queue that a separate monitor drains.
// Control outputs and latencies are checked inline.
module tb_otp_mixer;

    localparam int RB = 8;
`ifdef OTP_MIXER_COLLISION_EN
    localparam logic COLL_EXP = 1'b1;
`else
    localparam logic COLL_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        irst;
    logic        igen_otp;
    logic        inew_otp;
    logic        ootp_ready;
    logic [2:0]  isel_ram;
    logic [9:0]  iaddr;
    logic [3:0]  iwdata;
    logic        iwrite_en;
    logic [3:0]  ordata;
    logic        okey_init;
    logic        okey_req;
    logic        ikey_valid;
    logic [31:0] ikey;
    logic        ocollision;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] model [RB][1024];

    typedef struct {
        logic [3:0] exp;
        int         blk;
        int         addr;
    } rd_t;
    rd_t  sbq[$];
    logic rd_req  = 1'b0;
    logic rd_pend = 1'b0;

    // Keystream responder state.
    logic stall_mode   = 1'b0;
    logic stall_active = 1'b0;
    int   stall_left   = 0;
    int   stall_hi     = 0;
    int   hs_cnt       = 0;

    always #5 clk = ~clk;

    otp_mixer #(.RAM_BLOCKS(RB)) dut (
        .iclk       (clk),
        .irst       (irst),
        .igen_otp   (igen_otp),
        .inew_otp   (inew_otp),
        .ootp_ready (ootp_ready),
        .isel_ram   (isel_ram),
        .iaddr      (iaddr),
        .iwdata     (iwdata),
        .iwrite_en  (iwrite_en),
        .ordata     (ordata),
        .okey_init  (okey_init),
        .okey_req   (okey_req),
        .ikey_valid (ikey_valid),
        .ikey       (ikey),
        .ocollision (ocollision)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sd_write(input int b, input int a, input logic [3:0] v);
        isel_ram  = 3'(b);
        iaddr     = 10'(a);
        iwdata    = v;
        iwrite_en = 1'b1;
        tick(1);
        iwrite_en = 1'b0;
    endtask

    task automatic sd_read(input int b, input int a);
        rd_t e;
        e.exp  = model[b][a];
        e.blk  = b;
        e.addr = a;
        sbq.push_back(e);
        isel_ram = 3'(b);
        iaddr    = 10'(a);
        rd_req   = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    // The key word is always 32'h76543210, so nibble k is XORed with k mod 8.
    task automatic mix_model(input int b, input int upto);
        for (int k = 0; k < upto; k++) begin
            model[b][k] = model[b][k] ^ 4'(k % 8);
        end
    endtask

    task automatic pulse_gen();
        igen_otp = 1'b1;
        tick(1);
        igen_otp = 1'b0;
    endtask

    task automatic pulse_new(input string nm);
        inew_otp = 1'b1;
        tick(1);
        inew_otp = 1'b0;
        check({nm, "_init_hi"}, 32'(okey_init), 32'd1);
        check({nm, "_ready_lo"}, 32'(ootp_ready), 32'd0);
        tick(1);
        check({nm, "_init_lo"}, 32'(okey_init), 32'd0);
    endtask

    // Start a mix of block b and wait for ootp_ready.
    // Action 1 issues a conflicting SD write and a legal SD write mid-run.
    // Action 2 pulses igen_otp mid-run (the DUT must ignore it).
    task automatic run_mix(input int b, input int exp_lat, input int action, input string nm);
        int cnt;
        pulse_gen();
        check({nm, "_ready_clr"}, 32'(ootp_ready), 32'd0);
        cnt = 0;
        while (cnt < 6000) begin
            tick(1);
            cnt++;
            if (ootp_ready) break;
            if (action == 1 && cnt == 100) begin
                isel_ram = 3'd0; iaddr = 10'd10; iwdata = 4'h5; iwrite_en = 1'b1;
            end
            if (action == 1 && cnt == 101) iwrite_en = 1'b0;
            if (action == 1 && cnt == 150) check({nm, "_coll_mid"}, 32'(ocollision), 32'(COLL_EXP));
            if (action == 1 && cnt == 200) begin
                isel_ram = 3'd1; iaddr = 10'd5; iwdata = 4'h6; iwrite_en = 1'b1;
                model[1][5] = 4'h6;
            end
            if (action == 1 && cnt == 201) iwrite_en = 1'b0;
            if (action == 2 && cnt == 50) igen_otp = 1'b1;
            if (action == 2 && cnt == 51) igen_otp = 1'b0;
        end
        check({nm, "_latency"}, 32'(cnt), 32'(exp_lat));
        mix_model(b, 1024);
    endtask

    // Scoreboard monitor: compares SD read data one cycle after the address is presented.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: read data with no expected entry, got %0h", ordata);
                end else begin
                    e = sbq.pop_front();
                    n_tests++;
                    if (ordata !== e.exp) begin
                        n_fail++;
                        $display("FAIL rd_b%0d_a%0d: got %0h, expected %0h", e.blk, e.addr, ordata, e.exp);
                    end
                end
            end
            rd_pend = rd_req;
        end
    end

    // Keystream responder: valid is normally always high.
    // In stall mode it withholds the 3rd word for 50 cycles and counts how long okey_req stayed up.
    initial begin
        ikey       = 32'h7654_3210;
        ikey_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_mode && hs_cnt == 2 && (okey_req || stall_active) && stall_left > 0) begin
                stall_active = 1'b1;
                ikey_valid   = 1'b0;
                stall_left--;
                if (okey_req) stall_hi++;
            end else begin
                ikey_valid = 1'b1;
            end
            if (okey_req && ikey_valid) hs_cnt++;
        end
    end

    // Global watchdog.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        irst      = 1'b0;
        igen_otp  = 1'b0;
        inew_otp  = 1'b0;
        isel_ram  = 3'd0;
        iaddr     = 10'd0;
        iwdata    = 4'h0;
        iwrite_en = 1'b0;
        tick(2);
        check("rst_ready", 32'(ootp_ready), 32'd0);
        check("rst_req", 32'(okey_req), 32'd0);
        check("rst_init", 32'(okey_init), 32'd0);
        check("rst_coll", 32'(ocollision), 32'd0);
        check("rst_rdata", 32'(ordata), 32'd0);
        irst = 1'b1;
        tick(1);

        // Fill: block 0 with A, block b with b.
        for (int b = 0; b < RB; b++) begin
            for (int a = 0; a < 1024; a++) begin
                model[b][a] = (b == 0) ? 4'hA : 4'(b);
                sd_write(b, a, model[b][a]);
            end
        end
        pulse_new("new0");

        // Run 1: block 0, with a dropped write to block 0 and a legal write to block 1.
        run_mix(0, 2177, 1, "run1");
        check("run1_coll_end", 32'(ocollision), 32'(COLL_EXP));
        for (int a = 0; a < 16; a++) sd_read(0, a);
        for (int a = 1016; a < 1024; a++) sd_read(0, a);
        sd_read(1, 4);
        sd_read(1, 5);
        check("run1_ready_hold", 32'(ootp_ready), 32'd1);

        // Run 2: block 1, with a 50-cycle keystream stall on the 3rd request.
        hs_cnt = 0; stall_left = 50; stall_hi = 0; stall_active = 1'b0; stall_mode = 1'b1;
        run_mix(1, 2227, 0, "run2");
        stall_mode = 1'b0;
        check("run2_stall_req_hi", 32'(stall_hi), 32'd50);
        for (int a = 0; a < 24; a++) sd_read(1, a);
        sd_read(1, 1023);

        // Run 3: block 2, with an igen_otp mid-run that must be ignored.
        run_mix(2, 2177, 2, "run3");
        for (int a = 0; a < 8; a++) sd_read(2, a);

        // Runs 4..8: blocks 3..7.
        for (int b = 3; b < RB; b++) begin
            run_mix(b, 2177, 0, $sformatf("run_b%0d", b));
            sd_read(b, 0);
            sd_read(b, 7);
            sd_read(b, 1023);
        end

        // Run 9: the pointer wraps to block 0; mixing twice restores the A fill.
        run_mix(0, 2177, 0, "run9");
        for (int a = 0; a < 8; a++) sd_read(0, a);
        sd_read(0, 1023);
        sd_read(1, 0);
        check("coll_before_new", 32'(ocollision), 32'(COLL_EXP));
        pulse_new("new1");
        check("coll_after_new", 32'(ocollision), 32'd0);

        // Abort at nibble 500: nibble 499 is written on edge 1063 after igen, and edge 1064 samples inew_otp.
        pulse_gen();
        tick(1063);
        inew_otp = 1'b1;
        tick(1);
        inew_otp = 1'b0;
        check("abort_init_hi", 32'(okey_init), 32'd1);
        check("abort_ready", 32'(ootp_ready), 32'd0);
        check("abort_req", 32'(okey_req), 32'd0);
        tick(1);
        check("abort_init_lo", 32'(okey_init), 32'd0);
        mix_model(0, 500);
        for (int a = 496; a < 504; a++) sd_read(0, a);
        sd_read(0, 1023);

        // inew_otp and igen_otp together: the restart wins and the FSM stays idle.
        igen_otp = 1'b1;
        inew_otp = 1'b1;
        tick(1);
        igen_otp = 1'b0;
        inew_otp = 1'b0;
        check("both_init", 32'(okey_init), 32'd1);
        check("both_req", 32'(okey_req), 32'd0);
        tick(2);
        check("both_req_later", 32'(okey_req), 32'd0);

        // Reset at nibble 300: nibble 299 is written on edge 638, and edge 639 samples the reset.
        pulse_gen();
        tick(638);
        irst = 1'b0;
        tick(1);
        check("mrst_ready", 32'(ootp_ready), 32'd0);
        check("mrst_req", 32'(okey_req), 32'd0);
        check("mrst_init", 32'(okey_init), 32'd0);
        check("mrst_coll", 32'(ocollision), 32'd0);
        check("mrst_rdata", 32'(ordata), 32'd0);
        irst = 1'b1;
        mix_model(0, 300);
        tick(1);
        run_mix(0, 2177, 0, "run_post_rst");
        sd_read(0, 0);
        sd_read(0, 5);
        for (int a = 296; a < 304; a++) sd_read(0, a);
        for (int a = 498; a < 502; a++) sd_read(0, a);
        sd_read(0, 1023);
        sd_read(1, 1);

        tick(3);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/otp_mixer.md
OTP_MIXER -- requirements
Module: otp_mixer

Interface
REQ-001 SHALL have parameter RAM_BLOCKS, default 8, number of 1024x4-bit data blocks held.
REQ-002 SHALL have port iclk  input  1  system clock (36 MHz), sole clock.
REQ-003 SHALL have port irst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port igen_otp  input  1  pulse: XOR the next block with the pad.
REQ-005 SHALL have port inew_otp  input  1  pulse: restart the pad from block 0.
REQ-006 SHALL have port ootp_ready  output  1  current block is XORed.
REQ-007 SHALL have port isel_ram  input  $clog2(RAM_BLOCKS)  SD-side block select.
REQ-008 SHALL have port iaddr  input  10  SD-side nibble address.
REQ-009 SHALL have port iwdata  input  4  SD-side write data.
REQ-010 SHALL have port iwrite_en  input  1  SD-side write strobe.
REQ-011 SHALL have port ordata  output  4  SD-side read data.
REQ-012 SHALL have port okey_init  output  1  pulse: reseed the keystream generator.
REQ-013 SHALL have port okey_req  output  1  request one keystream word.
REQ-014 SHALL have port ikey_valid  input  1  keystream word valid.
REQ-015 SHALL have port ikey  input  32  keystream word.
REQ-016 SHALL have port ocollision  output  1  sticky SD-write/mix conflict flag.

Function
REQ-017 SHALL store RAM_BLOCKS x 1024 nibbles; the SD port and the mix engine each have an independent port.
REQ-018 SD port: ordata SHALL equal mem[isel_ram][iaddr] one cycle after address presentation; writes with iwrite_en SHALL complete on the same edge.
REQ-019 SHALL keep a block pointer blk; mixing applies to mem[blk].
REQ-020 FSM states SHALL be IDLE, KREQ, RD, WR and DONE.
REQ-021 IDLE->KREQ on igen_otp: clear ootp_ready, set nibble counter n=0.
REQ-022 KREQ: okey_req SHALL be held high until ikey_valid; ikey SHALL be latched on that cycle and the FSM SHALL move to RD; okey_req SHALL drop the next cycle.
REQ-023 RD: present address n (1 cycle); WR: write mem[blk][n] ^ key[4*(n%8)+3 : 4*(n%8)] (1 cycle).
REQ-024 After WR: if n=1023 go to DONE; else increment n, then go to KREQ if the new n%8=0, else RD.
REQ-025 One block SHALL take exactly 2048 cycles plus 128 keystream handshakes.
REQ-026 DONE: set ootp_ready=1; blk SHALL increment, wrapping RAM_BLOCKS-1 -> 0; return to IDLE.
REQ-027 ootp_ready SHALL stay high until the next igen_otp or inew_otp.
REQ-028 igen_otp outside IDLE SHALL be ignored.
REQ-029 inew_otp in any state SHALL abort mixing, set blk=0, clear ootp_ready, pulse okey_init for 1 cycle and enter IDLE; the partially mixed block stays as written.
REQ-030 inew_otp and igen_otp in the same cycle: inew_otp SHALL win, igen_otp SHALL be dropped.
REQ-031 An SD write to isel_ram==blk outside IDLE/DONE SHALL be dropped (memory unchanged).

Reset
REQ-032 With irst low at a clock edge: state=IDLE, blk=0, n=0, ootp_ready=0, okey_req=0, okey_init=0, ocollision=0, ordata=0.
REQ-033 Memory contents SHALL NOT be reset; reset mid-mix SHALL leave partially mixed data.

Configuration
REQ-034 Macro OTP_MIXER_COLLISION_EN defined: ocollision SHALL set on any write dropped per REQ-031 and clear only on reset or inew_otp.
REQ-035 Macro OTP_MIXER_COLLISION_EN undefined: ocollision SHALL be tied to 0; write dropping per REQ-031 still applies.

Verification
REQ-036 Fill block 0 with 4'hA, inew_otp, igen_otp, ikey=32'h76543210 on every request -> block 0 reads A,B,8,9,E,F,C,D repeating; ootp_ready high after 2048 cycles plus handshakes.
REQ-037 Eight igen_otp runs with RAM_BLOCKS=8 -> blocks 0..7 mixed in order; the ninth run mixes block 0 again (pointer wrap).
REQ-038 Hold ikey_valid low for 50 cycles on the 3rd request -> okey_req stays high for the whole stall; no nibble is written during the stall.
REQ-039 inew_otp at n=500 -> okey_init pulses 1 cycle; nibbles 0..499 are mixed and 500..1023 unchanged; blk=0; ootp_ready=0.
REQ-040 SD write of 4'h5 to block 0, address 10 during mixing of block 0 -> write is dropped; ocollision=1 with OTP_MIXER_COLLISION_EN defined, 0 without.
REQ-041 Reset asserted at n=300 -> all outputs at reset values next cycle; following igen_otp mixes block 0.
